// File: rtl/fifo_dual_port.sv
// -----------------------------------------------------------------------------
// fifo_dual_port
//
// Synchronous FIFO with two push ports and two pop ports. Up to two entries
// enter and two entries leave in a single cycle. Reads are
// first-word-fall-through: the two oldest entries are always visible on
// pop_data_1 / pop_data_2, and the matching valid flag qualifies each one.
// This FIFO sits in front of the memory model as its request queue.
//
// Handshake semantics (both directions):
//   A push on port N is accepted at a rising edge only when push_N is high and
//   the status flag that covers it is high. Port 1 uses ready_1. Port 2 uses
//   ready_2 when push_1 is also high, and ready_1 when it pushes alone.
//   A pop is accepted when pop_1 is high and valid_1 is high. Port 2 pops in
//   the same cycle only when pop_1, pop_2 and valid_2 are all high.
//   Requests that are not accepted are dropped and leave no trace: no write
//   and no pointer change. The ready and valid flags depend only on the
//   registered count. A pop in the same cycle therefore never makes room for
//   a push.
//
// Ports:
//   clk          clock; all state changes on the rising edge
//   rst_n        asynchronous active-low reset (empties the FIFO)
//   valid_flush  synchronous clear; beats every push and pop in its cycle
//   push_1       write request, port 1 (older of the two in a cycle)
//   push_data_1  data for port 1
//   ready_1      at least one free slot
//   push_2       write request, port 2 (younger of the two in a cycle)
//   push_data_2  data for port 2
//   ready_2      at least two free slots
//   pop_data_1   head entry (oldest)
//   valid_1      at least one entry held
//   pop_1        remove head
//   pop_data_2   entry after head (second oldest)
//   valid_2      at least two entries held
//   pop_2        remove second entry as well; only honoured with pop_1
// -----------------------------------------------------------------------------
module fifo_dual_port #(
    parameter int DW    = 16,
    parameter int DEPTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          valid_flush,
    input  logic          push_1,
    output logic          ready_1,
    input  logic [DW-1:0] push_data_1,
    input  logic          push_2,
    output logic          ready_2,
    input  logic [DW-1:0] push_data_2,
    output logic [DW-1:0] pop_data_1,
    output logic          valid_1,
    input  logic          pop_1,
    output logic [DW-1:0] pop_data_2,
    output logic          valid_2,
    input  logic          pop_2
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [AW:0] CNT_ONE       = (AW+1)'(1);
    localparam logic [AW:0] CNT_TWO       = (AW+1)'(2);
    localparam logic [AW:0] CNT_FULL_M1   = (AW+1)'(DEPTH - 1);
    localparam logic [AW:0] CNT_FULL_M2   = (AW+1)'(DEPTH - 2);
    localparam logic [AW-1:0] PTR_ONE     = AW'(1);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [AW:0]   count;

    logic          p1;
    logic          p2;
    logic          q1;
    logic          q2;
    logic [1:0]    n_push;
    logic [1:0]    n_pop;
    logic [AW-1:0] head_p1;
    logic [AW-1:0] tail_p1;

    // Status flags depend on the registered count only.
    assign ready_1 = (count <= CNT_FULL_M1);
    assign ready_2 = (count <= CNT_FULL_M2);
    assign valid_1 = (count >= CNT_ONE);
    assign valid_2 = (count >= CNT_TWO);

    // Pointers are exactly AW bits wide, so the +1 wraps at DEPTH.
    assign head_p1 = head + PTR_ONE;
    assign tail_p1 = tail + PTR_ONE;

    assign pop_data_1 = mem[head];
    assign pop_data_2 = mem[head_p1];

    // A lone push on port 2 needs only one slot. Paired with port 1 it takes
    // the second slot, so it needs two.
    assign p1 = push_1 & ready_1;
    assign p2 = push_1 ? (push_2 & ready_2) : (push_2 & ready_1);

    assign q1 = pop_1 & valid_1;
    assign q2 = pop_2 & pop_1 & valid_2;

    assign n_push = {1'b0, p1} + {1'b0, p2};
    assign n_pop  = {1'b0, q1} + {1'b0, q2};

    // Storage is not reset. Entries beyond count are never observable as valid.
    always_ff @(posedge clk) begin
        if (!valid_flush) begin
            if (p1) begin
                mem[tail] <= push_data_1;
            end
            if (p2) begin
                // Port 2 lands behind port 1 when both are accepted.
                if (p1) begin
                    mem[tail_p1] <= push_data_2;
                end else begin
                    mem[tail] <= push_data_2;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (valid_flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + AW'(n_pop);
            tail  <= tail + AW'(n_push);
            count <= count + (AW+1)'(n_push) - (AW+1)'(n_pop);
        end
    end

endmodule

// File: tb/tb_fifo_dual_port.sv
// -----------------------------------------------------------------------------
// tb_fifo_dual_port
//
// Directed bench for fifo_dual_port (DW=16, DEPTH=8). Each driver step pushes
// the data it expects to be accepted onto exp_q. A monitor process runs on
// the falling edge. When it sees an accepted pop, it takes the next entry from
// exp_q and compares it with the data the DUT presents. Status flags and
// head/second data are also checked directly against hand-computed values.
// -----------------------------------------------------------------------------
module tb_fifo_dual_port;

    localparam int DW    = 16;
    localparam int DEPTH = 8;

    logic          clk;
    logic          rst_n;
    logic          valid_flush;
    logic          push_1;
    logic          ready_1;
    logic [DW-1:0] push_data_1;
    logic          push_2;
    logic          ready_2;
    logic [DW-1:0] push_data_2;
    logic [DW-1:0] pop_data_1;
    logic          valid_1;
    logic          pop_1;
    logic [DW-1:0] pop_data_2;
    logic          valid_2;
    logic          pop_2;

    logic [DW-1:0] exp_q[$];
    int            checks;
    int            errors;

    fifo_dual_port #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .valid_flush (valid_flush),
        .push_1      (push_1),
        .ready_1     (ready_1),
        .push_data_1 (push_data_1),
        .push_2      (push_2),
        .ready_2     (ready_2),
        .push_data_2 (push_data_2),
        .pop_data_1  (pop_data_1),
        .valid_1     (valid_1),
        .pop_1       (pop_1),
        .pop_data_2  (pop_data_2),
        .valid_2     (valid_2),
        .pop_2       (pop_2)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares every accepted pop against the expected queue.
    always @(negedge clk) begin
        if (rst_n && pop_1 && valid_1) begin
            if (exp_q.size() == 0) begin
                chk("pop1_underflow", 32'd1, 32'd0);
            end else begin
                chk("pop_data_1", 32'(pop_data_1), 32'(exp_q.pop_front()));
            end
            if (pop_2 && valid_2) begin
                if (exp_q.size() == 0) begin
                    chk("pop2_underflow", 32'd1, 32'd0);
                end else begin
                    chk("pop_data_2", 32'(pop_data_2), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    // ---------------- driver ----------------
    // Drives one cycle of requests, then returns 1 time unit after the edge
    // with all requests cleared. acc1/acc2 say which pushes the bench expects
    // to be accepted, in port order.
    task automatic step(input logic fl,
                        input logic pu1, input logic [DW-1:0] d1,
                        input logic pu2, input logic [DW-1:0] d2,
                        input logic po1, input logic po2,
                        input logic acc1, input logic acc2);
        valid_flush = fl;
        push_1      = pu1;
        push_data_1 = d1;
        push_2      = pu2;
        push_data_2 = d2;
        pop_1       = po1;
        pop_2       = po2;
        if (acc1) exp_q.push_back(d1);
        if (acc2) exp_q.push_back(d2);
        @(posedge clk);
        #1;
        if (fl) exp_q.delete();
        valid_flush = 1'b0;
        push_1      = 1'b0;
        push_2      = 1'b0;
        pop_1       = 1'b0;
        pop_2       = 1'b0;
    endtask

    task automatic push1(input logic [DW-1:0] d);
        step(1'b0, 1'b1, d, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic pop1();
        step(1'b0, 1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        checks      = 0;
        errors      = 0;
        rst_n       = 1'b0;
        valid_flush = 1'b0;
        push_1      = 1'b0;
        push_2      = 1'b0;
        pop_1       = 1'b0;
        pop_2       = 1'b0;
        push_data_1 = '0;
        push_data_2 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid_1", 32'(valid_1), 32'd0);
        chk("rst_valid_2", 32'(valid_2), 32'd0);
        chk("rst_ready_1", 32'(ready_1), 32'd1);
        chk("rst_ready_2", 32'(ready_2), 32'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single push, then single pop.
        push1(16'h00A1);
        chk("t1_valid_1", 32'(valid_1), 32'd1);
        chk("t1_valid_2", 32'(valid_2), 32'd0);
        chk("t1_head", 32'(pop_data_1), 32'h00A1);
        pop1();
        chk("t1_empty", 32'(valid_1), 32'd0);

        // Dual push, then dual pop.
        step(1'b0, 1'b1, 16'h0011, 1'b1, 16'h0022, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("t2_valid_2", 32'(valid_2), 32'd1);
        chk("t2_head", 32'(pop_data_1), 32'h0011);
        chk("t2_second", 32'(pop_data_2), 32'h0022);
        step(1'b0, 1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("t2_empty", 32'(valid_1), 32'd0);

        // Fill to 7 entries, then to full.
        for (int i = 0; i < 7; i++) push1(16'h0100 + 16'(i));
        chk("t3_ready_1_at7", 32'(ready_1), 32'd1);
        chk("t3_ready_2_at7", 32'(ready_2), 32'd0);
        step(1'b0, 1'b1, 16'h0107, 1'b1, 16'h0199, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("t3_ready_1_full", 32'(ready_1), 32'd0);
        chk("t3_valid_2_full", 32'(valid_2), 32'd1);
        step(1'b0, 1'b1, 16'h01EE, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t3_head_kept", 32'(pop_data_1), 32'h0100);
        chk("t3_second_kept", 32'(pop_data_2), 32'h0101);

        // Full: a push with a pop is dropped, and the pop is taken (count 7).
        step(1'b0, 1'b1, 16'h01FF, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t4_ready_1_at7", 32'(ready_1), 32'd1);
        chk("t4_ready_2_at7", 32'(ready_2), 32'd0);
        chk("t4_head", 32'(pop_data_1), 32'h0101);
        repeat (7) pop1();
        chk("t4_drained", 32'(valid_1), 32'd0);

        // 20 values through the FIFO. Each middle step pops the last entry
        // while pushing a new one, so the count stays at 1 and the pointers wrap.
        push1(16'd0);
        for (int i = 1; i < 20; i++) begin
            step(1'b0, 1'b1, 16'(i), 1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0);
            if (i == 10) begin
                chk("t4_one_valid_1", 32'(valid_1), 32'd1);
                chk("t4_one_valid_2", 32'(valid_2), 32'd0);
            end
        end
        pop1();
        chk("t4_wrap_empty", 32'(valid_1), 32'd0);

        // Lone push on port 2, then pop_2 without pop_1.
        step(1'b0, 1'b0, '0, 1'b1, 16'h0055, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("t5_head", 32'(pop_data_1), 32'h0055);
        chk("t5_valid_2", 32'(valid_2), 32'd0);
        push1(16'h0066);
        step(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("t5_pop2_only_valid_2", 32'(valid_2), 32'd1);
        chk("t5_pop2_only_head", 32'(pop_data_1), 32'h0055);
        chk("t5_pop2_only_second", 32'(pop_data_2), 32'h0066);
        step(1'b0, 1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("t5_empty", 32'(valid_1), 32'd0);

        // Five entries, then flush together with a push.
        step(1'b0, 1'b1, 16'h0301, 1'b1, 16'h0302, 1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 16'h0303, 1'b1, 16'h0304, 1'b0, 1'b0, 1'b1, 1'b1);
        push1(16'h0305);
        chk("t6_count5_ready_2", 32'(ready_2), 32'd1);
        step(1'b1, 1'b1, 16'h0777, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t6_flush_valid_1", 32'(valid_1), 32'd0);
        chk("t6_flush_ready_2", 32'(ready_2), 32'd1);
        push1(16'h0888);
        chk("t6_after_flush_valid_2", 32'(valid_2), 32'd0);
        pop1();

        // Asynchronous reset mid-stream.
        step(1'b0, 1'b1, 16'h0401, 1'b1, 16'h0402, 1'b0, 1'b0, 1'b1, 1'b1);
        push1(16'h0403);
        chk("t7_pre_rst_valid_2", 32'(valid_2), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t7_async_valid_1", 32'(valid_1), 32'd0);
        chk("t7_async_ready_2", 32'(ready_2), 32'd1);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("t7_post_rst_valid_1", 32'(valid_1), 32'd0);

        chk("leftover_expected", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
